zone_gesture_ctrl: RTL and testbench

Frame-rate gesture controller that sequences the per-frame dominant-zone results of the color zone detector into discrete swipe events. On each end-of-frame strobe it samples the winning zone of the selected hand color. It waits for that zone to be stable for a number of frames, then tracks movement relative to that anchor zone. A LEFT/RIGHT/UP/DOWN event is emitted over a valid/ready handshake to the downstream command logic, followed by a cooldown period. It sits between the zone detector outputs and the gesture command consumer, in the pixel clock domain.

---
 rtl/zone_gesture_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_zone_gesture_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zone_gesture_ctrl.sv
// zone_gesture_ctrl: turns per-frame dominant-zone results into debounced
// LEFT/RIGHT/UP/DOWN swipe events delivered over a valid/ready handshake.
module zone_gesture_ctrl #(
   parameter int unsigned NX            = 8,
   parameter int unsigned NY            = 6,
   parameter int unsigned ZONES         = NX * NY,
   parameter int unsigned ZW            = 7,
   parameter int unsigned STABLE_FRAMES = 3,
   parameter int unsigned MOVE_TH       = 2,
   parameter int unsigned WINDOW_FRAMES = 8,
   parameter int unsigned COOL_FRAMES   = 4
) (
   input  logic          pclk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          hand_sel,
   input  logic          frame_done,
   input  logic [ZW-1:0] blue_zone,
   input  logic [ZW-1:0] red_zone,
   output logic          evt_valid,
   output logic [2:0]    evt_code,
   input  logic          evt_ready,
   output logic [ZW-1:0] anchor_zone,
   output logic [2:0]    state
);

   localparam int unsigned GMAX = (NX > NY) ? NX : NY;
   localparam int unsigned DW   = $clog2(GMAX) + 1;
   localparam int unsigned SW   = $clog2(STABLE_FRAMES + 1);
   localparam int unsigned FW   = $clog2(WINDOW_FRAMES + 1);
   localparam int unsigned CW   = $clog2(COOL_FRAMES + 1);

   // All-ones is never a valid zone, so it doubles as the "no previous zone" marker.
   localparam logic [ZW-1:0] Z_NONE = '1;

   localparam logic [2:0] EVT_NONE  = 3'd0;
   localparam logic [2:0] EVT_LEFT  = 3'd1;
   localparam logic [2:0] EVT_RIGHT = 3'd2;
   localparam logic [2:0] EVT_UP    = 3'd3;
   localparam logic [2:0] EVT_DOWN  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_TRACK = 3'd1,
      ST_EMIT  = 3'd2,
      ST_COOL  = 3'd3
   } state_e;

   state_e        state_q,      state_d;
   logic [SW-1:0] stable_cnt_q, stable_cnt_d;
   logic [ZW-1:0] prev_z_q,     prev_z_d;
   logic [ZW-1:0] anchor_q,     anchor_d;
   logic [FW-1:0] frame_cnt_q,  frame_cnt_d;
   logic [CW-1:0] cool_cnt_q,   cool_cnt_d;
   logic          evt_valid_q,  evt_valid_d;
   logic [2:0]    evt_code_q,   evt_code_d;

   logic [ZW-1:0]        z_c;
   logic                 z_valid_c;
   logic signed [DW-1:0] dx_c, dy_c;
   logic [DW-1:0]        adx_c, ady_c;
   logic                 fire_c;
   logic [2:0]           fire_code_c;

   function automatic logic [DW-1:0] zone_col(input logic [ZW-1:0] zz);
      return DW'(32'(zz) % NX);
   endfunction

   function automatic logic [DW-1:0] zone_row(input logic [ZW-1:0] zz);
      return DW'(32'(zz) / NX);
   endfunction

   assign z_c       = hand_sel ? red_zone : blue_zone;
   assign z_valid_c = (32'(z_c) < ZONES);

   // Displacement of the tracked zone relative to the anchor, and its magnitude.
   always_comb begin
      dx_c  = $signed(zone_col(z_c)) - $signed(zone_col(anchor_q));
      dy_c  = $signed(zone_row(z_c)) - $signed(zone_row(anchor_q));
      adx_c = dx_c[DW-1] ? $unsigned(-dx_c) : $unsigned(dx_c);
      ady_c = dy_c[DW-1] ? $unsigned(-dy_c) : $unsigned(dy_c);
   end

   // Direction decode; horizontal wins a tie, invalid zones never fire.
   always_comb begin
      fire_c      = 1'b0;
      fire_code_c = EVT_NONE;
      if (z_valid_c && (adx_c >= DW'(MOVE_TH)) && (adx_c >= ady_c)) begin
         fire_c      = 1'b1;
         fire_code_c = dx_c[DW-1] ? EVT_LEFT : EVT_RIGHT;
      end else if (z_valid_c && (ady_c >= DW'(MOVE_TH))) begin
         fire_c      = 1'b1;
         fire_code_c = dy_c[DW-1] ? EVT_UP : EVT_DOWN;
      end
   end

   // State register and datapath flops.
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         stable_cnt_q <= '0;
         prev_z_q     <= Z_NONE;
         anchor_q     <= '0;
         frame_cnt_q  <= '0;
         cool_cnt_q   <= '0;
         evt_valid_q  <= 1'b0;
         evt_code_q   <= EVT_NONE;
      end else begin
         state_q      <= state_d;
         stable_cnt_q <= stable_cnt_d;
         prev_z_q     <= prev_z_d;
         anchor_q     <= anchor_d;
         frame_cnt_q  <= frame_cnt_d;
         cool_cnt_q   <= cool_cnt_d;
         evt_valid_q  <= evt_valid_d;
         evt_code_q   <= evt_code_d;
      end
   end

   // Next-state and counter update.
   always_comb begin
      state_d      = state_q;
      stable_cnt_d = stable_cnt_q;
      prev_z_d     = prev_z_q;
      anchor_d     = anchor_q;
      frame_cnt_d  = frame_cnt_q;
      cool_cnt_d   = cool_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (!en) begin
               stable_cnt_d = '0;
            end else if (frame_done) begin
               if (!z_valid_c) begin
                  stable_cnt_d = '0;
               end else if (z_c == prev_z_q) begin
                  if (stable_cnt_q != SW'(STABLE_FRAMES)) begin
                     stable_cnt_d = stable_cnt_q + SW'(1);
                  end
               end else begin
                  stable_cnt_d = SW'(1);
               end
               prev_z_d = z_c;
               if (z_valid_c && (stable_cnt_d == SW'(STABLE_FRAMES))) begin
                  anchor_d    = z_c;
                  frame_cnt_d = '0;
                  state_d     = ST_TRACK;
               end
            end
         end

         ST_TRACK: begin
            if (!en) begin
               stable_cnt_d = '0;
               state_d      = ST_IDLE;
            end else if (frame_done) begin
               frame_cnt_d = frame_cnt_q + FW'(1);
               if (fire_c) begin
                  state_d = ST_EMIT;
               end else if (frame_cnt_d == FW'(WINDOW_FRAMES)) begin
                  stable_cnt_d = '0;
                  state_d      = ST_IDLE;
               end
            end
         end

         // Pending event survives en low and frame strobes until accepted.
         ST_EMIT: begin
            if (evt_valid_q && evt_ready) begin
               cool_cnt_d = '0;
               state_d    = ST_COOL;
            end
         end

         ST_COOL: begin
            if (!en) begin
               stable_cnt_d = '0;
               state_d      = ST_IDLE;
            end else if (frame_done) begin
               cool_cnt_d = cool_cnt_q + CW'(1);
               if (cool_cnt_d == CW'(COOL_FRAMES)) begin
                  stable_cnt_d = '0;
                  prev_z_d     = Z_NONE;
                  state_d      = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Event outputs: code latched on entry to EMIT, held until the handshake completes.
   always_comb begin
      evt_valid_d = 1'b0;
      evt_code_d  = EVT_NONE;
      if (state_d == ST_EMIT) begin
         evt_valid_d = 1'b1;
         evt_code_d  = (state_q == ST_EMIT) ? evt_code_q : fire_code_c;
      end
   end

   assign evt_valid   = evt_valid_q;
   assign evt_code    = evt_code_q;
   assign anchor_zone = anchor_q;
   assign state       = state_q;

endmodule

// File: tb/tb_zone_gesture_ctrl.sv
// Self-checking bench for zone_gesture_ctrl: directed swipe scenarios plus
// randomized traffic, compared every cycle against a frame-level reference model.
module tb_zone_gesture_ctrl;

   localparam int NX      = 8;
   localparam int NY      = 6;
   localparam int ZONES   = NX * NY;
   localparam int STABLE  = 3;
   localparam int MOVE_TH = 2;
   localparam int WINDOW  = 8;
   localparam int COOL    = 4;

   logic       pclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic       hand_sel = 1'b0;
   logic       frame_done = 1'b0;
   logic [6:0] blue_zone = 7'd0;
   logic [6:0] red_zone = 7'd0;
   logic       evt_ready = 1'b0;
   logic       evt_valid;
   logic [2:0] evt_code;
   logic [6:0] anchor_zone;
   logic [2:0] state;

   zone_gesture_ctrl dut (
      .pclk        (pclk),
      .rst_n       (rst_n),
      .en          (en),
      .hand_sel    (hand_sel),
      .frame_done  (frame_done),
      .blue_zone   (blue_zone),
      .red_zone    (red_zone),
      .evt_valid   (evt_valid),
      .evt_code    (evt_code),
      .evt_ready   (evt_ready),
      .anchor_zone (anchor_zone),
      .state       (state)
   );

   always #5 pclk = ~pclk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: mode 0 idle, 1 watching for motion, 2 event pending, 3 cooldown.
   int m_mode   = 0;
   int m_stable = 0;
   int m_prev   = -1;
   int m_anchor = 0;
   int m_frames = 0;
   int m_cool   = 0;
   int m_valid  = 0;
   int m_code   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      int z, dx, dy, adx, ady;
      bit zv;
      z   = hand_sel ? int'(red_zone) : int'(blue_zone);
      zv  = (z < ZONES);
      dx  = (z % NX) - (m_anchor % NX);
      dy  = (z / NX) - (m_anchor / NX);
      adx = (dx < 0) ? -dx : dx;
      ady = (dy < 0) ? -dy : dy;
      if (!rst_n) begin
         m_mode = 0; m_stable = 0; m_prev = -1; m_anchor = 0;
         m_frames = 0; m_cool = 0; m_valid = 0; m_code = 0;
      end else begin
         case (m_mode)
            0: begin
               if (!en) m_stable = 0;
               else if (frame_done) begin
                  if (!zv) m_stable = 0;
                  else if (z == m_prev) m_stable = (m_stable < STABLE) ? m_stable + 1 : STABLE;
                  else m_stable = 1;
                  m_prev = z;
                  if (zv && m_stable == STABLE) begin
                     m_anchor = z; m_frames = 0; m_mode = 1;
                  end
               end
            end
            1: begin
               if (!en) begin
                  m_mode = 0; m_stable = 0;
               end else if (frame_done) begin
                  m_frames++;
                  if (zv && adx >= MOVE_TH && adx >= ady) begin
                     m_code = (dx < 0) ? 1 : 2; m_valid = 1; m_mode = 2;
                  end else if (zv && ady >= MOVE_TH) begin
                     m_code = (dy < 0) ? 3 : 4; m_valid = 1; m_mode = 2;
                  end else if (m_frames == WINDOW) begin
                     m_mode = 0; m_stable = 0;
                  end
               end
            end
            2: begin
               if (evt_ready) begin
                  m_valid = 0; m_code = 0; m_cool = 0; m_mode = 3;
               end
            end
            default: begin
               if (!en) begin
                  m_mode = 0; m_stable = 0;
               end else if (frame_done) begin
                  m_cool++;
                  if (m_cool == COOL) begin
                     m_mode = 0; m_stable = 0; m_prev = -1;
                  end
               end
            end
         endcase
      end
   endtask

   // One clock: model follows the inputs seen at the edge, outputs compared 1 time unit later.
   task automatic step();
      @(posedge pclk);
      model_step();
      #1;
      check("evt_valid", 32'(evt_valid), 32'(m_valid));
      check("evt_code", 32'(evt_code), 32'(m_code));
      check("anchor_zone", 32'(anchor_zone), 32'(m_anchor));
      check("state", 32'(state), 32'(m_mode));
   endtask

   task automatic frame(input int bz, input int rz);
      blue_zone  = 7'(bz);
      red_zone   = 7'(rz);
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      step();
   endtask

   task automatic accept();
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
   endtask

   task automatic arm_blue(input int z);
      repeat (STABLE) frame(z, 48);
   endtask

   task automatic cool_down();
      repeat (COOL) frame(48, 48);
   endtask

   initial begin
      int last_b, last_r;
      // Reset state
      rst_n = 1'b0;
      step();
      step();
      check("reset_state", 32'(state), 32'd0);
      check("reset_valid", 32'(evt_valid), 32'd0);
      rst_n = 1'b1;
      step();

      // Right swipe
      arm_blue(10);
      check("right_armed_state", 32'(state), 32'd1);
      check("right_anchor", 32'(anchor_zone), 32'd10);
      blue_zone = 7'd13; frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      check("right_latency_valid", 32'(evt_valid), 32'd1);
      check("right_code", 32'(evt_code), 32'd2);
      accept();
      check("right_code_cleared", 32'(evt_code), 32'd0);
      cool_down();

      // Up swipe
      arm_blue(20);
      frame(4, 48);
      check("up_code", 32'(evt_code), 32'd3);
      accept();
      cool_down();

      // Tie case resolves horizontally
      arm_blue(0);
      frame(18, 48);
      check("tie_code", 32'(evt_code), 32'd2);
      accept();
      cool_down();

      // Window timeout
      arm_blue(10);
      repeat (WINDOW - 1) frame(11, 48);
      check("timeout_still_track", 32'(state), 32'd1);
      frame(11, 48);
      check("timeout_idle", 32'(state), 32'd0);
      check("timeout_no_event", 32'(evt_valid), 32'd0);

      // Invalid zone restarts arming
      frame(5, 48); frame(5, 48); frame(48, 48);
      frame(5, 48); frame(5, 48);
      check("invalid_not_armed", 32'(state), 32'd0);
      frame(5, 48);
      check("invalid_rearmed", 32'(state), 32'd1);
      check("invalid_anchor", 32'(anchor_zone), 32'd5);
      // Leave via enable low
      en = 1'b0;
      step();
      check("en_low_idle", 32'(state), 32'd0);
      check("en_low_anchor_kept", 32'(anchor_zone), 32'd5);
      en = 1'b1;

      // Backpressure with frame strobes in EMIT
      arm_blue(10);
      frame(13, 48);
      for (int i = 0; i < 50; i++) begin
         frame_done = (i == 10 || i == 25 || i == 40);
         blue_zone  = 7'd20;
         step();
         check("bp_valid", 32'(evt_valid), 32'd1);
         check("bp_code", 32'(evt_code), 32'd2);
      end
      frame_done = 1'b0;
      accept();
      check("bp_cool", 32'(state), 32'd3);
      repeat (COOL - 1) frame(48, 48);
      check("bp_still_cool", 32'(state), 32'd3);
      frame(48, 48);
      check("bp_idle", 32'(state), 32'd0);

      // Reset while in EMIT
      arm_blue(10);
      frame(13, 48);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("rst_emit_valid", 32'(evt_valid), 32'd0);
      check("rst_emit_code", 32'(evt_code), 32'd0);
      check("rst_emit_anchor", 32'(anchor_zone), 32'd0);
      check("rst_emit_state", 32'(state), 32'd0);

      // Red hand select, left swipe
      hand_sel = 1'b1;
      repeat (STABLE) frame(48, 30);
      frame(48, 27);
      check("red_left_code", 32'(evt_code), 32'd1);
      accept();
      cool_down();
      hand_sel = 1'b0;

      // Randomized traffic
      last_b = 10;
      last_r = 30;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(9) >= 7) last_b = int'($urandom_range(55));
         if ($urandom_range(9) >= 7) last_r = int'($urandom_range(55));
         blue_zone  = 7'(last_b);
         red_zone   = 7'(last_r);
         frame_done = ($urandom_range(3) == 0);
         evt_ready  = ($urandom_range(2) == 0);
         en         = ($urandom_range(39) != 0);
         rst_n      = ($urandom_range(499) != 0);
         if ($urandom_range(49) == 0) hand_sel = ~hand_sel;
         step();
      end
      rst_n = 1'b1;
      frame_done = 1'b0;
      evt_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
